// File: rtl/timer_pkg.sv
// Shared types and default widths for the countdown timer and its prescaler.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } timer_state_t;

    localparam int DEFAULT_CNT_BITS      = 16;
    localparam int DEFAULT_PRESCALE_BITS = 8;

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider: while enabled, asserts tick once every (div+1) cycles.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIV_BITS = DEFAULT_PRESCALE_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    input  logic [DIV_BITS-1:0] div,
    output logic                tick
);

    logic [DIV_BITS-1:0] cnt_reg;

    assign tick = enable && (cnt_reg == div);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with pause, abort and optional auto-reload.
// Define COUNTDOWN_TIMER_PRESCALE_EN to divide the tick rate by (prescale_div+1).
module countdown_timer
    import timer_pkg::*;
#(
    parameter int NUM_CNT_BITS  = DEFAULT_CNT_BITS,
    parameter int PRESCALE_BITS = DEFAULT_PRESCALE_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic                     auto_reload,
    input  logic [PRESCALE_BITS-1:0] prescale_div,
    input  logic                     pause,
    input  logic                     abort,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     expire_pulse,
    output logic                     busy,
    output logic                     done
);

    timer_state_t            state_reg, state_next;
    logic [NUM_CNT_BITS-1:0] count_reg, count_next;
    logic [NUM_CNT_BITS-1:0] reload_reg;
    logic                    auto_reg;
    logic                    expire_reg, expire_next;
    logic                    load_accept;
    logic                    run_active;
    logic                    tick;
    logic                    at_one;

    assign load_accept = load_valid && load_ready;
    assign run_active  = (state_reg == RUN) && !pause;
    assign at_one      = (count_reg == NUM_CNT_BITS'(1));

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] presc_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg <= '0;
        end else if (load_accept) begin
            presc_reg <= prescale_div;
        end
    end

    timer_prescaler #(
        .DIV_BITS (PRESCALE_BITS)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (abort || load_accept),
        .enable (run_active),
        .div    (presc_reg),
        .tick   (tick)
    );
`else
    logic unused_prescale;
    assign unused_prescale = ^prescale_div;
    assign tick            = run_active;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (load_valid) begin
                        state_next = (load_val == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else if (tick && at_one && !auto_reg) begin
                        state_next = DONE;
                    end
                end
                PAUSED: begin
                    if (!pause) begin
                        state_next = RUN;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        load_ready = ((state_reg == IDLE) || (state_reg == DONE)) && !abort;
        busy       = (state_reg == RUN) || (state_reg == PAUSED);
        done       = (state_reg == DONE);
    end

    // Abort dominates everything, so an expiry in the same cycle is dropped.
    always_comb begin
        count_next  = count_reg;
        expire_next = 1'b0;
        if (abort) begin
            count_next = '0;
        end else if (load_accept) begin
            count_next  = load_val;
            expire_next = (load_val == '0);
        end else if (tick) begin
            if (at_one) begin
                expire_next = 1'b1;
                count_next  = auto_reg ? reload_reg : '0;
            end else if (count_reg != '0) begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg  <= '0;
            reload_reg <= '0;
            auto_reg   <= 1'b0;
            expire_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            expire_reg <= expire_next;
            if (load_accept) begin
                reload_reg <= load_val;
                auto_reg   <= auto_reload;
            end
        end
    end

    assign count_out    = count_reg;
    assign expire_pulse = expire_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed scenarios then random traffic.
module tb_countdown_timer;

    localparam int W  = 16;
    localparam int PW = 8;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [W-1:0]  load_val;
    logic          auto_reload;
    logic [PW-1:0] prescale_div;
    logic          pause;
    logic          abort;
    logic [W-1:0]  count_out;
    logic          expire_pulse;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    countdown_timer #(
        .NUM_CNT_BITS  (W),
        .PRESCALE_BITS (PW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_val     (load_val),
        .auto_reload  (auto_reload),
        .prescale_div (prescale_div),
        .pause        (pause),
        .abort        (abort),
        .count_out    (count_out),
        .expire_pulse (expire_pulse),
        .busy         (busy),
        .done         (done)
    );

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         exp;
        logic         bsy;
        logic         dn;
        logic         rdy;
    } snap_t;

    snap_t exp_q[$];
    int    errors     = 0;
    int    checks     = 0;
    int    n_expiries = 0;
    int    cycle_no   = 0;

    // Reference model, advanced once per clock edge from the stimulus alone.
    int m_mode   = M_IDLE;
    int m_count  = 0;
    int m_reload = 0;
    int m_div    = 0;
    int m_phase  = 0;
    bit m_auto   = 1'b0;
    bit m_exp    = 1'b0;

    task automatic model_step(input bit rst, input bit lv, input int val, input bit ar,
                              input int pd, input bit pz, input bit ab);
        bit t;
        m_exp = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_count = 0; m_reload = 0; m_div = 0; m_phase = 0; m_auto = 1'b0;
        end else if (ab) begin
            m_mode = M_IDLE; m_count = 0; m_phase = 0;
        end else if ((m_mode == M_IDLE || m_mode == M_DONE) && lv) begin
            m_phase = 0; m_div = pd; m_reload = val; m_auto = ar;
            if (val == 0) begin
                m_mode = M_DONE; m_count = 0; m_exp = 1'b1;
            end else begin
                m_mode = M_RUN; m_count = val;
            end
        end else if (m_mode == M_RUN) begin
            if (pz) begin
                m_mode = M_PAUSED;
            end else begin
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
                t = (m_phase == m_div);
                m_phase = t ? 0 : m_phase + 1;
`else
                t = 1'b1;
`endif
                if (t) begin
                    if (m_count == 1) begin
                        m_exp = 1'b1;
                        if (m_auto) m_count = m_reload;
                        else begin m_count = 0; m_mode = M_DONE; end
                    end else if (m_count > 0) begin
                        m_count = m_count - 1;
                    end
                end
            end
        end else if (m_mode == M_PAUSED) begin
            if (!pz) m_mode = M_RUN;
        end
    endtask

    task automatic drive(input bit rst, input bit lv, input int val, input bit ar,
                         input int pd, input bit pz, input bit ab);
        snap_t s;
        @(posedge clk);
        #1;
        reset        = rst;
        load_valid   = lv;
        load_val     = W'(val);
        auto_reload  = ar;
        prescale_div = PW'(pd);
        pause        = pz;
        abort        = ab;
        s.cnt = W'(m_count);
        s.exp = m_exp;
        s.bsy = (m_mode == M_RUN) || (m_mode == M_PAUSED);
        s.dn  = (m_mode == M_DONE);
        s.rdy = ((m_mode == M_IDLE) || (m_mode == M_DONE)) && !ab && !rst;
        exp_q.push_back(s);
        model_step(rst, lv, val, ar, pd, pz, ab);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares every presented cycle against the oldest expectation.
    always @(negedge clk) begin
        snap_t e;
        snap_t g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g.cnt = count_out;
            g.exp = expire_pulse;
            g.bsy = busy;
            g.dn  = done;
            g.rdy = reset ? e.rdy : load_ready;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cycle%0d: got count=%0d exp=%b busy=%b done=%b rdy=%b, required count=%0d exp=%b busy=%b done=%b rdy=%b",
                         cycle_no, g.cnt, g.exp, g.bsy, g.dn, g.rdy, e.cnt, e.exp, e.bsy, e.dn, e.rdy);
            end else begin
                $display("cycle%0d ok count=%0d exp=%b busy=%b done=%b rdy=%b",
                         cycle_no, g.cnt, g.exp, g.bsy, g.dn, g.rdy);
            end
            if (expire_pulse === 1'b1) n_expiries++;
            cycle_no++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_val = '0; auto_reload = 1'b0;
        prescale_div = '0; pause = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);

        idle(2);
        drive(0, 1, 5, 0, 0, 0, 0);      // one-shot count from 5
        idle(8);
        drive(0, 1, 3, 1, 0, 0, 0);      // periodic reload
        idle(10);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 4, 0, 0, 0, 0);      // pause after two decrements
        idle(2);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 0);
        idle(7);
        drive(0, 1, 10, 0, 0, 0, 0);     // abort at 6 with a competing load
        idle(4);
        drive(0, 1, 7, 0, 0, 0, 1);
        idle(2);
        drive(0, 1, 0, 1, 0, 0, 0);      // zero load expires at once
        idle(2);
        drive(0, 1, 2, 0, 3, 0, 0);
        idle(10);
        drive(0, 1, 9, 0, 0, 0, 0);      // reset mid-count
        idle(2);
        drive(1, 1, 4, 0, 0, 0, 0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 12)),
                  $urandom_range(0, 1),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 24) == 0));
        end
        idle(2);
        @(posedge clk);
        @(negedge clk);
        #1;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        checks++;
        if (n_expiries == 0) begin
            errors++;
            $display("FAIL expiries: observed %0d expire pulses, required at least 1", n_expiries);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
